// File: rtl/rabbit_state_core_if.sv
// rabbit_state_core_if: load/step handshakes and state taps of the Rabbit core.
// ks_out/ks_valid exist only when RABBIT_EXTRACT_EN is defined.
interface rabbit_state_core_if #(
    parameter int ITER_W = 4
);
    logic              load_valid;
    logic              load_ready;
    logic [255:0]      x_in;
    logic [255:0]      c_in;
    logic              phi_in;
    logic              step_valid;
    logic              step_ready;
    logic [ITER_W-1:0] step_count;
    logic              busy;
    logic              done;
    logic [255:0]      x_out;
    logic [255:0]      c_out;
    logic              phi_out;
`ifdef RABBIT_EXTRACT_EN
    logic [127:0]      ks_out;
    logic              ks_valid;
`endif

    modport master (
        output load_valid, x_in, c_in, phi_in,
        output step_valid, step_count,
        input  load_ready, step_ready, busy, done,
`ifdef RABBIT_EXTRACT_EN
        input  ks_out, ks_valid,
`endif
        input  x_out, c_out, phi_out
    );

    modport slave (
        input  load_valid, x_in, c_in, phi_in,
        input  step_valid, step_count,
        output load_ready, step_ready, busy, done,
`ifdef RABBIT_EXTRACT_EN
        output ks_out, ks_valid,
`endif
        output x_out, c_out, phi_out
    );
endinterface

// File: rtl/rabbit_state_core.sv
// rabbit_state_core: Rabbit counter update, g-function and mix, N iterations per request.
// Define RABBIT_EXTRACT_EN to add the registered 128-bit keystream extractor.
module rabbit_state_core #(
    parameter int ITER_W = 4,
    parameter int PIPE_G = 0
) (
    input logic               clk,
    input logic               rst_n,
    rabbit_state_core_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CNT,
        GFN,
        MIX
    } state_t;

    localparam logic [255:0] A_VEC = {
        32'hD34D34D3, 32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3,
        32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3, 32'h4D34D34D
    };

    state_t            state_q;
    logic [255:0]      x_q;
    logic [255:0]      c_q;
    logic              phi_q;
    logic [ITER_W-1:0] rem_q;
    logic [255:0]      g_q;
    logic              done_q;

    logic [255:0]      c_d;
    logic              phi_d;
    logic [255:0]      g_d;
    logic [255:0]      g_use;
    logic [255:0]      x_d;
    logic [32:0]       csum [8];
    logic [8:0]        cy;

    function automatic logic [31:0] g_fn(input logic [31:0] u,
                                         input logic [31:0] v);
        logic [31:0] s;
        logic [63:0] sq;
        s  = u + v;
        sq = {32'b0, s} * {32'b0, s};
        return sq[63:32] ^ sq[31:0];
    endfunction

    function automatic logic [31:0] rotl16(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

    function automatic logic [31:0] rotl8(input logic [31:0] v);
        return {v[23:0], v[31:24]};
    endfunction

    // Counter carry ripples through all eight words in one cycle.
    always_comb begin
        cy    = '0;
        c_d   = '0;
        cy[0] = phi_q;
        for (int j = 0; j < 8; j++) begin
            csum[j] = {1'b0, c_q[32*j +: 32]}
                    + {1'b0, A_VEC[32*j +: 32]}
                    + {32'b0, cy[j]};
            cy[j+1] = csum[j][32];
            c_d[32*j +: 32] = csum[j][31:0];
        end
        phi_d = cy[8];
    end

    always_comb begin
        g_d = '0;
        for (int j = 0; j < 8; j++) begin
            g_d[32*j +: 32] = g_fn(x_q[32*j +: 32], c_q[32*j +: 32]);
        end
    end

    // C is already updated when MIX (or GFN) samples g.
    assign g_use = (PIPE_G != 0) ? g_q : g_d;

    always_comb begin
        x_d = '0;
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) begin
                x_d[32*j +: 32] = g_use[32*j +: 32]
                    + rotl16(g_use[32*((j+7)%8) +: 32])
                    + rotl16(g_use[32*((j+6)%8) +: 32]);
            end else begin
                x_d[32*j +: 32] = g_use[32*j +: 32]
                    + rotl8(g_use[32*((j+7)%8) +: 32])
                    + g_use[32*((j+6)%8) +: 32];
            end
        end
    end

`ifdef RABBIT_EXTRACT_EN
    logic [127:0] ks_q;
    logic [127:0] ks_d;
    logic         ks_valid_q;

    always_comb begin
        ks_d = {
            x_d[223:208] ^ x_d[47:32],
            x_d[207:192] ^ x_d[127:112],
            x_d[159:144] ^ x_d[239:224],
            x_d[143:128] ^ x_d[63:48],
            x_d[95:80]   ^ x_d[175:160],
            x_d[79:64]   ^ x_d[255:240],
            x_d[31:16]   ^ x_d[111:96],
            x_d[15:0]    ^ x_d[191:176]
        };
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            c_q        <= '0;
            phi_q      <= 1'b0;
            rem_q      <= '0;
            g_q        <= '0;
            done_q     <= 1'b0;
`ifdef RABBIT_EXTRACT_EN
            ks_q       <= '0;
            ks_valid_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
`ifdef RABBIT_EXTRACT_EN
            ks_valid_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        x_q   <= bus.x_in;
                        c_q   <= bus.c_in;
                        phi_q <= bus.phi_in;
                    end else if (bus.step_valid) begin
                        if (bus.step_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rem_q   <= bus.step_count;
                            state_q <= CNT;
                        end
                    end
                end
                CNT: begin
                    c_q     <= c_d;
                    phi_q   <= phi_d;
                    state_q <= (PIPE_G != 0) ? GFN : MIX;
                end
                GFN: begin
                    g_q     <= g_d;
                    state_q <= MIX;
                end
                MIX: begin
                    x_q   <= x_d;
                    rem_q <= rem_q - 1'b1;
`ifdef RABBIT_EXTRACT_EN
                    ks_q       <= ks_d;
                    ks_valid_q <= 1'b1;
`endif
                    if (rem_q == ITER_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= CNT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.step_ready = (state_q == IDLE) && !bus.load_valid;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.x_out      = x_q;
    assign bus.c_out      = c_q;
    assign bus.phi_out    = phi_q;
`ifdef RABBIT_EXTRACT_EN
    assign bus.ks_out     = ks_q;
    assign bus.ks_valid   = ks_valid_q;
`endif

endmodule

// File: tb/tb_rabbit_state_core.sv
// tb_rabbit_state_core: vector table plus done-triggered scoreboard
// against an independent Rabbit iteration model.
module tb_rabbit_state_core;

  localparam int ITER_W = 4;
  localparam int PIPE_G = 0;
  localparam int LAT    = 2 + PIPE_G;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rabbit_state_core_if #(.ITER_W(ITER_W)) bus();

  rabbit_state_core #(
    .ITER_W(ITER_W),
    .PIPE_G(PIPE_G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [255:0] x;
    logic [255:0] c;
    logic         phi;
    int           due;
  } exp_t;

  typedef struct {
    logic [255:0] x;
    logic [255:0] c;
    logic         phi;
    int           n;
    bit           fixed_c;
    logic [255:0] exp_c;
    logic         exp_phi;
  } vec_t;

  exp_t sb[$];
  logic [127:0] ks_sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [255:0] m_x, m_c;
  logic         m_phi;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, want);
    end
  endtask

  task automatic chki(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic logic [31:0] gm(input logic [31:0] u,
                                     input logic [31:0] v);
    logic [31:0] t;
    logic [63:0] s;
    t = u + v;
    s = {32'b0, t};
    s = s * s;
    return s[63:32] ^ s[31:0];
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void model_step();
    logic [31:0] a [8];
    logic [31:0] g [8];
    logic [31:0] xn [8];
    logic [32:0] t;
    logic        cy;
    a = '{32'h4D34D34D, 32'hD34D34D3, 32'h34D34D34, 32'h4D34D34D,
          32'hD34D34D3, 32'h34D34D34, 32'h4D34D34D, 32'hD34D34D3};
    cy = m_phi;
    for (int j = 0; j < 8; j++) begin
      t = {1'b0, m_c[32*j +: 32]} + {1'b0, a[j]} + {32'b0, cy};
      cy = t[32];
      m_c[32*j +: 32] = t[31:0];
    end
    m_phi = cy;
    for (int j = 0; j < 8; j++)
      g[j] = gm(m_x[32*j +: 32], m_c[32*j +: 32]);
    xn[0] = g[0] + rl(g[7], 16) + rl(g[6], 16);
    xn[1] = g[1] + rl(g[0], 8) + g[7];
    xn[2] = g[2] + rl(g[1], 16) + rl(g[0], 16);
    xn[3] = g[3] + rl(g[2], 8) + g[1];
    xn[4] = g[4] + rl(g[3], 16) + rl(g[2], 16);
    xn[5] = g[5] + rl(g[4], 8) + g[3];
    xn[6] = g[6] + rl(g[5], 16) + rl(g[4], 16);
    xn[7] = g[7] + rl(g[6], 8) + g[5];
    m_x = {xn[7], xn[6], xn[5], xn[4], xn[3], xn[2], xn[1], xn[0]};
  endfunction

  function automatic logic [127:0] ks_of(input logic [255:0] x);
    logic [31:0] w [8];
    for (int j = 0; j < 8; j++) w[j] = x[32*j +: 32];
    return {w[6][31:16] ^ w[1][15:0], w[6][15:0] ^ w[3][31:16],
            w[4][31:16] ^ w[7][15:0], w[4][15:0] ^ w[1][31:16],
            w[2][31:16] ^ w[5][15:0], w[2][15:0] ^ w[7][31:16],
            w[0][31:16] ^ w[3][15:0], w[0][15:0] ^ w[5][31:16]};
  endfunction

  // Advance the model n iterations, queueing keystream expectations.
  function automatic void model_run(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      ks_sb.push_back(ks_of(m_x));
    end
  endfunction

  function automatic logic [255:0] r256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 want done=0");
      end else begin
        e = sb.pop_front();
        chki("done_cycle", cyc, e.due);
        chk("x_final", bus.x_out, e.x);
        chk("c_final", bus.c_out, e.c);
        chk1("phi_final", bus.phi_out, e.phi);
      end
    end
`ifdef RABBIT_EXTRACT_EN
    if (bus.ks_valid) begin
      if (ks_sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ks_unexpected: got ks_valid=1 want 0");
      end else begin
        chk("ks_out", {128'b0, bus.ks_out}, {128'b0, ks_sb.pop_front()});
      end
    end
`endif
  end

  task automatic do_load(input logic [255:0] x, input logic [255:0] c,
                         input logic p);
    bus.load_valid = 1'b1;
    bus.x_in = x;
    bus.c_in = c;
    bus.phi_in = p;
    #1 chk1("load_ready", bus.load_ready, 1'b1);
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    m_x = x;
    m_c = c;
    m_phi = p;
    chk("x_after_load", bus.x_out, x);
    chk("c_after_load", bus.c_out, c);
  endtask

  task automatic do_step(input int n, input exp_t e, input bit track);
    exp_t q;
    q = e;
    bus.step_valid = 1'b1;
    bus.step_count = ITER_W'(n);
    q.due = cyc + 1 + n * LAT;
    if (track) sb.push_back(q);
    #1 chk1("step_ready", bus.step_ready, 1'b1);
    @(posedge clk);
    #1 bus.step_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1 chk1("idle_after", bus.busy, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];
    exp_t e;
    logic [255:0] sx, sc, nx;
    logic sp;

    bus.load_valid = 1'b0;
    bus.step_valid = 1'b0;
    bus.step_count = '0;
    bus.x_in = '0;
    bus.c_in = '0;
    bus.phi_in = 1'b0;

    vt[0] = '{x: '0, c: '0, phi: 1'b0, n: 1, fixed_c: 1'b1,
      exp_c: 256'hD34D34D3_4D34D34D_34D34D34_D34D34D3_4D34D34D_34D34D34_D34D34D3_4D34D34D,
      exp_phi: 1'b0};
    vt[1] = '{x: r256(), c: 256'hFFFFFFFF, phi: 1'b0, n: 1, fixed_c: 1'b1,
      exp_c: 256'hD34D34D3_4D34D34D_34D34D34_D34D34D3_4D34D34D_34D34D34_D34D34D4_4D34D34C,
      exp_phi: 1'b0};
    vt[2] = '{x: r256(), c: '1, phi: 1'b1, n: 1, fixed_c: 1'b0,
      exp_c: '0, exp_phi: 1'b0};
    vt[3] = '{x: r256(), c: r256(), phi: 1'b0, n: 2, fixed_c: 1'b0,
      exp_c: '0, exp_phi: 1'b0};
    vt[4] = '{x: r256(), c: r256(), phi: 1'b1, n: 3, fixed_c: 1'b0,
      exp_c: '0, exp_phi: 1'b0};
    vt[5] = '{x: r256(), c: r256(), phi: 1'b0, n: 15, fixed_c: 1'b0,
      exp_c: '0, exp_phi: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", bus.x_out, '0);
    chk("rst_c", bus.c_out, '0);
    chk1("rst_phi", bus.phi_out, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
`ifdef RABBIT_EXTRACT_EN
    chk1("rst_ksv", bus.ks_valid, 1'b0);
    chk("rst_ks", {128'b0, bus.ks_out}, '0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_load(vt[i].x, vt[i].c, vt[i].phi);
      model_run(vt[i].n);
      e.x = m_x;
      e.c = vt[i].fixed_c ? vt[i].exp_c : m_c;
      e.phi = vt[i].fixed_c ? vt[i].exp_phi : m_phi;
      e.due = 0;
      do_step(vt[i].n, e, 1'b1);
      wait_drain();
    end

    // Per-iteration X tracking across a 3-step request.
    do_load(r256(), r256(), 1'b1);
    sx = m_x; sc = m_c; sp = m_phi;
    model_run(3);
    e.x = m_x; e.c = m_c; e.phi = m_phi; e.due = 0;
    m_x = sx; m_c = sc; m_phi = sp;
    do_step(3, e, 1'b1);
    chk1("busy_mid", bus.busy, 1'b1);
    for (int it = 0; it < 3; it++) begin
      repeat (LAT) @(posedge clk);
      #1;
      model_step();
      chk("x_iter", bus.x_out, m_x);
    end
    wait_drain();

    // Zero-count request: done next cycle, nothing moves.
    e.x = m_x; e.c = m_c; e.phi = m_phi; e.due = 0;
    do_step(0, e, 1'b1);
    wait_drain();

    // Load and step together: load wins, step is not taken.
    nx = r256();
    bus.load_valid = 1'b1;
    bus.step_valid = 1'b1;
    bus.step_count = ITER_W'(2);
    bus.x_in = nx;
    bus.c_in = m_c;
    bus.phi_in = m_phi;
    #1;
    chk1("contend_step_rdy", bus.step_ready, 1'b0);
    chk1("contend_load_rdy", bus.load_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.step_valid = 1'b0;
    m_x = nx;
    chk1("contend_busy", bus.busy, 1'b0);
    chk("contend_x", bus.x_out, nx);
    repeat (4) @(posedge clk);
    #1;

    // Requests while busy are ignored.
    sx = m_x; sc = m_c; sp = m_phi;
    model_run(2);
    e.x = m_x; e.c = m_c; e.phi = m_phi; e.due = 0;
    do_step(2, e, 1'b1);
    bus.load_valid = 1'b1;
    bus.step_valid = 1'b1;
    bus.x_in = ~sx;
    bus.c_in = ~sc;
    #1;
    chk1("busy_load_rdy", bus.load_ready, 1'b0);
    chk1("busy_step_rdy", bus.step_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.step_valid = 1'b0;
    wait_drain();

    // Reset in the middle of an iteration.
    do_load(r256(), r256(), 1'b1);
    e.x = '0; e.c = '0; e.phi = 1'b0; e.due = 0;
    do_step(5, e, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x", bus.x_out, '0);
    chk("midrst_c", bus.c_out, '0);
    chk1("midrst_phi", bus.phi_out, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk1("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_x", bus.x_out, '0);
`ifdef RABBIT_EXTRACT_EN
    chki("ks_pending", ks_sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
